// File: rtl/alarm_pkg.sv
// Shared encodings and constants for the multi-channel alarm bank.
// Optional ALARM_CATCHUP_EN selects range-based (jump-tolerant) triggering.
package alarm_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ONCE  = 2'd1;
    localparam logic [1:0] MODE_DAILY = 2'd2;

    localparam int SECS_PER_DAY = 86400;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RING,
        S_SNOOZE
    } state_t;

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: target/mode storage, write handling, trigger compare.
// ALARM_CATCHUP_EN: fire when the counter steps over the target, not only onto it.
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [CNT_W-1:0] set_time,
    input  logic [1:0]       set_mode,
    input  logic [CNT_W-1:0] counter,
    input  logic [CNT_W-1:0] counter_q,
    input  logic             sec_evt,
    output logic [CNT_W-1:0] target,
    output logic [1:0]       mode,
    output logic             trig
);

    logic hit;

`ifdef ALARM_CATCHUP_EN
    assign hit = (counter_q < target) && (target <= counter);
`else
    logic unused_prev;
    assign unused_prev = ^counter_q;
    assign hit = (counter == target);
`endif

    // A write in the same cycle overrides any trigger on this channel.
    assign trig = sec_evt && (mode != MODE_OFF) && hit && !wr;

    // Store writes; on trigger retire once-alarms and advance daily ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target <= '0;
            mode   <= MODE_OFF;
        end else if (wr) begin
            target <= set_time;
            mode   <= (set_mode == MODE_ONCE || set_mode == MODE_DAILY)
                      ? set_mode : MODE_OFF;
        end else if (trig) begin
            if (mode == MODE_ONCE) mode <= MODE_OFF;
            else target <= target + CNT_W'(SECS_PER_DAY);
        end
    end

endmodule

// File: rtl/alarm_bank.sv
// N-channel alarm unit driving one shared ring output with snooze/timeout.
// Build option ALARM_CATCHUP_EN is forwarded to every alarm_channel.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS  = 4,
    parameter int CNT_W       = 64,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int SEL_W       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set,
    input  logic [SEL_W-1:0]      sel,
    input  logic [CNT_W-1:0]      set_time,
    input  logic [1:0]            set_mode,
    input  logic [CNT_W-1:0]      counter,
    input  logic                  cancel,
    input  logic                  snooze,
    output logic [CNT_W-1:0]      sel_time,
    output logic [1:0]            sel_mode,
    output logic                  ring,
    output logic [SEL_W-1:0]      ring_id,
    output logic [NUM_ALARMS-1:0] pending
);

    logic [CNT_W-1:0]      counter_q;
    logic                  sec_evt;
    logic [CNT_W-1:0]      targets [NUM_ALARMS];
    logic [1:0]            modes   [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] trig;
    logic [NUM_ALARMS-1:0] wr;
    logic [NUM_ALARMS-1:0] first_hot;
    logic [NUM_ALARMS-1:0] serve;
    logic [SEL_W-1:0]      first_idx;
    logic                  force_idle;
    state_t                state;
    logic [31:0]           timer;
    logic [CNT_W-1:0]      wake;

    // Remember last counter value to detect a new second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) counter_q <= '0;
        else        counter_q <= counter;
    end

    assign sec_evt = (counter != counter_q);

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
        assign wr[g] = set && (sel == SEL_W'(g));
        alarm_channel #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr       (wr[g]),
            .set_time (set_time),
            .set_mode (set_mode),
            .counter  (counter),
            .counter_q(counter_q),
            .sec_evt  (sec_evt),
            .target   (targets[g]),
            .mode     (modes[g]),
            .trig     (trig[g])
        );
    end

    // Readback of the selected channel; out-of-range selects read zero.
    always_comb begin
        sel_time = '0;
        sel_mode = MODE_OFF;
        if (int'(sel) < NUM_ALARMS) begin
            sel_time = targets[sel];
            sel_mode = modes[sel];
        end
    end

    // Lowest-index pending channel wins service.
    always_comb begin
        first_idx = '0;
        first_hot = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                first_idx    = SEL_W'(i);
                first_hot    = '0;
                first_hot[i] = 1'b1;
            end
        end
    end

    assign serve = (state == S_IDLE) ? first_hot : '0;

    // Disabling the active channel aborts its ring or snooze.
    assign force_idle = set && (state != S_IDLE) && (sel == ring_id)
                        && (set_mode != MODE_ONCE) && (set_mode != MODE_DAILY);

    // Collect triggers; writes and service clear their bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= (pending | trig) & ~wr & ~serve;
    end

    // Ring/snooze sequencer with registered ring outputs and timers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ring    <= 1'b0;
            ring_id <= '0;
            timer   <= '0;
            wake    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (|pending) begin
                        state   <= S_RING;
                        ring    <= 1'b1;
                        ring_id <= first_idx;
                        timer   <= 32'(RING_SECS);
                    end
                end
                S_RING: begin
                    if (force_idle || cancel) begin
                        state <= S_IDLE;
                        ring  <= 1'b0;
                    end else if (snooze) begin
                        state <= S_SNOOZE;
                        ring  <= 1'b0;
                        wake  <= counter + CNT_W'(SNOOZE_SECS);
                    end else if (sec_evt) begin
                        if (timer <= 32'd1) begin
                            state <= S_IDLE;
                            ring  <= 1'b0;
                            timer <= '0;
                        end else begin
                            timer <= timer - 32'd1;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (force_idle || cancel) begin
                        state <= S_IDLE;
                    end else if (sec_evt && counter >= wake) begin
                        state <= S_RING;
                        ring  <= 1'b1;
                        timer <= 32'(RING_SECS);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ring  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank: stimulus queues expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_alarm_bank;

    localparam logic [63:0] T = 64'd1704067200;

    typedef enum int {K_RING, K_ID, K_PEND, K_TIME, K_MODE} kind_e;
    typedef struct {
        string       name;
        kind_e       kind;
        logic [63:0] val;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        set;
    logic [1:0]  sel;
    logic [63:0] set_time;
    logic [1:0]  set_mode;
    logic [63:0] counter;
    logic        cancel;
    logic        snooze;
    logic [63:0] sel_time;
    logic [1:0]  sel_mode;
    logic        ring;
    logic [1:0]  ring_id;
    logic [3:0]  pending;

    exp_t        q[$];
    int          checks;
    int          failures;

    alarm_bank dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .set     (set),
        .sel     (sel),
        .set_time(set_time),
        .set_mode(set_mode),
        .counter (counter),
        .cancel  (cancel),
        .snooze  (snooze),
        .sel_time(sel_time),
        .sel_mode(sel_mode),
        .ring    (ring),
        .ring_id (ring_id),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        m_e;
    logic [63:0] m_act;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            m_e = q.pop_front();
            case (m_e.kind)
                K_RING:  m_act = {63'd0, ring};
                K_ID:    m_act = {62'd0, ring_id};
                K_PEND:  m_act = {60'd0, pending};
                K_TIME:  m_act = sel_time;
                default: m_act = {62'd0, sel_mode};
            endcase
            checks++;
            if (m_act !== m_e.val) begin
                failures++;
                $display("FAIL %s: got %0d expected %0d",
                         m_e.name, m_act, m_e.val);
            end
        end
    end

    task automatic chk(input string n, input kind_e k, input logic [63:0] v);
        q.push_back('{n, k, v});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] s, input logic [63:0] t,
                      input logic [1:0] m);
        set      = 1'b1;
        sel      = s;
        set_time = t;
        set_mode = m;
        step();
        set = 1'b0;
    endtask

    task automatic rd(input logic [1:0] s, input logic [63:0] t,
                      input logic [1:0] m);
        sel = s;
        chk("rd_time", K_TIME, t);
        chk("rd_mode", K_MODE, {62'd0, m});
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        set      = 1'b0;
        sel      = 2'd0;
        set_time = '0;
        set_mode = 2'd0;
        counter  = T - 64'd1;
        cancel   = 1'b0;
        snooze   = 1'b0;
        step();
        chk("rst_ring", K_RING, 0);
        chk("rst_pend", K_PEND, 0);
        chk("rst_id", K_ID, 0);
        chk("rst_time", K_TIME, 0);
        chk("rst_mode", K_MODE, 0);
        step();
        rst_n = 1'b1;
        step();

        wr(2'd0, T, 2'd1);
        wr(2'd1, T + 64'd20, 2'd2);
        wr(2'd2, T + 64'd30, 2'd1);
        rd(2'd0, T, 2'd1);
        rd(2'd1, T + 64'd20, 2'd2);
        rd(2'd2, T + 64'd30, 2'd1);
        rd(2'd3, 64'd0, 2'd0);

        counter = T;
        chk("trig_ring0", K_RING, 0);
        step();
        sel = 2'd0;
        chk("trig_pend", K_PEND, 1);
        chk("trig_ring1", K_RING, 0);
        chk("once_clear", K_MODE, 0);
        step();
        chk("ring_on", K_RING, 1);
        chk("ring_id0", K_ID, 0);
        chk("ring_pend", K_PEND, 0);

        for (int k = 1; k <= 60; k++) begin
            counter = T + 64'(k);
            step();
            chk("timeout", K_RING, (k < 60) ? 64'd1 : 64'd0);
            if (k == 21) chk("acc_pend1", K_PEND, 2);
            if (k == 31) chk("acc_pend2", K_PEND, 6);
        end
        step();
        chk("ch1_ring", K_RING, 1);
        chk("ch1_id", K_ID, 1);
        chk("ch1_pend", K_PEND, 4);

        repeat (3) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        sel = 2'd1;
        chk("cancel", K_RING, 0);
        chk("daily_time", K_TIME, 64'd1704153620);
        chk("daily_mode", K_MODE, 2);
        step();
        chk("ch2_ring", K_RING, 1);
        chk("ch2_id", K_ID, 2);
        chk("ch2_pend", K_PEND, 0);

        snooze = 1'b1;
        step();
        snooze = 1'b0;
        chk("snooze", K_RING, 0);
        chk("snooze_id", K_ID, 2);
        counter = T + 64'd359;
        step();
        chk("snooze_299", K_RING, 0);
        counter = T + 64'd360;
        step();
        chk("wake_ring", K_RING, 1);
        chk("wake_id", K_ID, 2);
        cancel = 1'b1;
        snooze = 1'b1;
        step();
        cancel = 1'b0;
        snooze = 1'b0;
        chk("cxl_wins", K_RING, 0);
        step();
        chk("cxl_idle", K_RING, 0);
        chk("cxl_pend", K_PEND, 0);

        wr(2'd0, T + 64'd1000, 2'd1);
        wr(2'd3, T + 64'd1000, 2'd1);
        counter = T + 64'd999;
        step();
        counter = T + 64'd1000;
        step();
        chk("dual_pend", K_PEND, 9);
        step();
        chk("dual_ring0", K_RING, 1);
        chk("dual_id0", K_ID, 0);
        chk("dual_pend8", K_PEND, 8);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("dual_cxl", K_RING, 0);
        chk("dual_keep", K_PEND, 8);
        step();
        chk("dual_ring3", K_RING, 1);
        chk("dual_id3", K_ID, 3);
        chk("dual_clr3", K_PEND, 0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("dual_off", K_RING, 0);

        wr(2'd0, T + 64'd2000, 2'd1);
        set      = 1'b1;
        sel      = 2'd0;
        set_time = T + 64'd2000;
        set_mode = 2'd1;
        counter  = T + 64'd2000;
        step();
        set = 1'b0;
        chk("setwin_pend", K_PEND, 0);
        chk("setwin_mode", K_MODE, 1);
        step();
        chk("setwin_pend2", K_PEND, 0);
        chk("setwin_ring", K_RING, 0);

        wr(2'd0, T + 64'd3050, 2'd1);
        wr(2'd3, T + 64'd3050, 2'd1);
        counter = T + 64'd3000;
        step();
        counter = T + 64'd3100;
        step();
        step();
`ifdef ALARM_CATCHUP_EN
        chk("jump_ring", K_RING, 1);
        chk("jump_id0", K_ID, 0);
        chk("jump_pend", K_PEND, 8);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        step();
        chk("jump_id3", K_ID, 3);
        chk("jump_ring3", K_RING, 1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("jump_off", K_RING, 0);
`else
        chk("jump_ring", K_RING, 0);
        chk("jump_pend", K_PEND, 0);
        step();
        chk("jump_quiet", K_RING, 0);
`endif

        wr(2'd1, T + 64'd4000, 2'd2);
        counter = T + 64'd4000;
        step();
        step();
        chk("fi_ring", K_RING, 1);
        chk("fi_id", K_ID, 1);
        set      = 1'b1;
        sel      = 2'd1;
        set_time = T + 64'd4000;
        set_mode = 2'd3;
        step();
        set = 1'b0;
        chk("fi_idle", K_RING, 0);
        chk("fi_mode3", K_MODE, 0);
        chk("fi_pend", K_PEND, 0);
        step();

        wr(2'd2, T + 64'd5000, 2'd1);
        counter = T + 64'd5000;
        step();
        step();
        chk("pre_rst_ring", K_RING, 1);
        step();
        rst_n = 1'b0;
        #1;
        sel = 2'd2;
        chk("rst_mid_ring", K_RING, 0);
        chk("rst_mid_pend", K_PEND, 0);
        chk("rst_mid_id", K_ID, 0);
        chk("rst_mid_time", K_TIME, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst", K_RING, 0);
        step();

        for (int i = 0; i < 10 && q.size() > 0; i++) step();
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d queued expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
